// File: rtl/opnd_fetch.sv
// Operand fetch stage: resolves source operands through the forwarding network,
// registers the ID/EX micro-op and sequences the two-phase INT push/branch.
module opnd_fetch #(
  parameter int unsigned     DW      = 16,
  parameter int unsigned     AW      = 4,
  parameter int unsigned     NFWD    = 2,
  parameter logic [AW-1:0]   SP_ADDR = 4'd8,
  parameter logic [DW-1:0]   INT_VEC = 16'h0008
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_pc,
  input  logic [DW-1:0]      in_imm,
  input  logic               in_re0,
  input  logic               in_re1,
  input  logic               in_use_imm,
  input  logic [AW-1:0]      in_addr0,
  input  logic [AW-1:0]      in_addr1,
  input  logic [AW-1:0]      in_waddr,
  input  logic               in_we,
  input  logic               in_int,
  input  logic [7:0]         in_op,
  input  logic [3:0]         in_int_no,
  output logic [AW-1:0]      rf_addr0,
  output logic [AW-1:0]      rf_addr1,
  input  logic [DW-1:0]      rf_data0,
  input  logic [DW-1:0]      rf_data1,
  input  logic [NFWD-1:0]    fwd_we,
  input  logic [NFWD-1:0]    fwd_load,
  input  logic [NFWD*AW-1:0] fwd_waddr,
  input  logic [NFWD*DW-1:0] fwd_wdata,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_op,
  output logic [1:0]         out_phase,
  output logic [DW-1:0]      out_op0,
  output logic [DW-1:0]      out_op1,
  output logic               out_we,
  output logic [AW-1:0]      out_waddr,
  output logic [DW-1:0]      out_pc,
  output logic               br_valid,
  output logic [DW-1:0]      br_addr,
  output logic               stall_o,
  output logic               int_busy
);

  typedef enum logic [1:0] {IDLE, INT1, INT2} state_e;

  state_e          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_op_q, out_op_d;
  logic [1:0]      out_phase_q, out_phase_d;
  logic [DW-1:0]   out_op0_q, out_op0_d;
  logic [DW-1:0]   out_op1_q, out_op1_d;
  logic            out_we_q, out_we_d;
  logic [AW-1:0]   out_waddr_q, out_waddr_d;
  logic [DW-1:0]   out_pc_q, out_pc_d;
  logic            br_valid_q, br_valid_d;
  logic [DW-1:0]   br_addr_q, br_addr_d;
  logic [3:0]      int_no_q, int_no_d;
  logic [DW-1:0]   int_pc_q, int_pc_d;
  logic [7:0]      int_op_q, int_op_d;

  logic            re0_c, re1_c;
  logic [AW-1:0]   addr0_c;
  logic [DW-1:0]   opnd0_c, opnd1_c;
  logic            hit0_c, hit1_c, haz0_c, haz1_c, hazard_c;
  logic            accept_c;

  // Operand 0 reads SP for an INT accept and for the phase-2 re-fetch.
  always_comb begin
    addr0_c = in_addr0;
    re0_c   = 1'b0;
    re1_c   = 1'b0;
    if (state_q == IDLE) begin
      if (in_int) addr0_c = SP_ADDR;
      re0_c = in_valid && (in_int || in_re0);
      re1_c = in_valid && !in_int && in_re1 && !in_use_imm;
    end else if (state_q == INT2) begin
      addr0_c = SP_ADDR;
      re0_c   = 1'b1;
    end
  end

  assign rf_addr0 = addr0_c;
  assign rf_addr1 = in_addr1;

  // Lowest forwarding index is youngest, so the first match wins.
  always_comb begin
    opnd0_c = '0;
    opnd1_c = '0;
    hit0_c  = 1'b0;
    hit1_c  = 1'b0;
    haz0_c  = 1'b0;
    haz1_c  = 1'b0;
    if (re0_c) opnd0_c = rf_data0;
    if (re1_c) opnd1_c = rf_data1;
    for (int j = 0; j < NFWD; j++) begin
      if (re0_c && !hit0_c && fwd_we[j] && fwd_waddr[j*AW +: AW] == addr0_c) begin
        hit0_c  = 1'b1;
        opnd0_c = fwd_wdata[j*DW +: DW];
        haz0_c  = fwd_load[j];
      end
      if (re1_c && !hit1_c && fwd_we[j] && fwd_waddr[j*AW +: AW] == in_addr1) begin
        hit1_c  = 1'b1;
        opnd1_c = fwd_wdata[j*DW +: DW];
        haz1_c  = fwd_load[j];
      end
    end
    if (in_use_imm) opnd1_c = in_imm;
  end

  assign hazard_c = haz0_c || haz1_c;
  assign stall_o  = hazard_c;
  assign int_busy = (state_q != IDLE);
  assign in_ready = (!out_valid_q || out_ready) && !hazard_c && (state_q == IDLE) && !flush;
  assign accept_c = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_op_d    = out_op_q;
    out_phase_d = out_phase_q;
    out_op0_d   = out_op0_q;
    out_op1_d   = out_op1_q;
    out_we_d    = out_we_q;
    out_waddr_d = out_waddr_q;
    out_pc_d    = out_pc_q;
    br_valid_d  = 1'b0;
    br_addr_d   = br_addr_q;
    int_no_d    = int_no_q;
    int_pc_d    = int_pc_q;
    int_op_d    = int_op_q;

    if (out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          out_valid_d = 1'b1;
          out_op_d    = in_op;
          out_op0_d   = opnd0_c;
          out_pc_d    = in_pc;
          if (in_int) begin
            out_phase_d = 2'd1;
            out_op1_d   = in_pc;
            out_we_d    = 1'b1;
            out_waddr_d = SP_ADDR;
            int_no_d    = in_int_no;
            int_pc_d    = in_pc;
            int_op_d    = in_op;
            state_d     = INT1;
          end else begin
            out_phase_d = 2'd0;
            out_op1_d   = opnd1_c;
            out_we_d    = in_we;
            out_waddr_d = in_waddr;
          end
        end
      end
      INT1: begin
        if (out_valid_q && out_ready) state_d = INT2;
      end
      INT2: begin
        if ((!out_valid_q || out_ready) && !hazard_c) begin
          out_valid_d = 1'b1;
          out_op_d    = int_op_q;
          out_phase_d = 2'd2;
          out_op0_d   = opnd0_c;
          out_op1_d   = DW'(int_no_q);
          out_we_d    = 1'b1;
          out_waddr_d = SP_ADDR;
          out_pc_d    = int_pc_q;
          br_valid_d  = 1'b1;
          br_addr_d   = INT_VEC;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush overrides any capture or INT progress in the same cycle.
    if (flush) begin
      out_valid_d = 1'b0;
      br_valid_d  = 1'b0;
      state_d     = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_op_q    <= '0;
      out_phase_q <= '0;
      out_op0_q   <= '0;
      out_op1_q   <= '0;
      out_we_q    <= 1'b0;
      out_waddr_q <= '0;
      out_pc_q    <= '0;
      br_valid_q  <= 1'b0;
      br_addr_q   <= '0;
      int_no_q    <= '0;
      int_pc_q    <= '0;
      int_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_op_q    <= out_op_d;
      out_phase_q <= out_phase_d;
      out_op0_q   <= out_op0_d;
      out_op1_q   <= out_op1_d;
      out_we_q    <= out_we_d;
      out_waddr_q <= out_waddr_d;
      out_pc_q    <= out_pc_d;
      br_valid_q  <= br_valid_d;
      br_addr_q   <= br_addr_d;
      int_no_q    <= int_no_d;
      int_pc_q    <= int_pc_d;
      int_op_q    <= int_op_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_op    = out_op_q;
  assign out_phase = out_phase_q;
  assign out_op0   = out_op0_q;
  assign out_op1   = out_op1_q;
  assign out_we    = out_we_q;
  assign out_waddr = out_waddr_q;
  assign out_pc    = out_pc_q;
  assign br_valid  = br_valid_q;
  assign br_addr   = br_addr_q;

endmodule

// File: tb/tb_opnd_fetch.sv
// Directed bench for opnd_fetch: forwarding priority, load hazards, backpressure,
// INT sequencing, flush and reset abort.
module tb_opnd_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [15:0] in_pc, in_imm;
  logic        in_re0, in_re1, in_use_imm;
  logic [3:0]  in_addr0, in_addr1, in_waddr;
  logic        in_we, in_int;
  logic [7:0]  in_op;
  logic [3:0]  in_int_no;
  logic [3:0]  rf_addr0, rf_addr1;
  logic [15:0] rf_data0, rf_data1;
  logic [1:0]  fwd_we, fwd_load;
  logic [7:0]  fwd_waddr;
  logic [31:0] fwd_wdata;
  logic        flush;
  logic        out_valid, out_ready;
  logic [7:0]  out_op;
  logic [1:0]  out_phase;
  logic [15:0] out_op0, out_op1, out_pc;
  logic        out_we;
  logic [3:0]  out_waddr;
  logic        br_valid;
  logic [15:0] br_addr;
  logic        stall_o, int_busy;

  int total = 0;
  int bad   = 0;

  logic [15:0] rf [16];

  always #5 clk = ~clk;

  // Register file model: r[i] = 0x1000+i, SP (r8) = 0x00F0.
  assign rf_data0 = rf[rf_addr0];
  assign rf_data1 = rf[rf_addr1];

  opnd_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_re0(in_re0), .in_re1(in_re1), .in_use_imm(in_use_imm),
    .in_addr0(in_addr0), .in_addr1(in_addr1), .in_waddr(in_waddr),
    .in_we(in_we), .in_int(in_int), .in_op(in_op), .in_int_no(in_int_no),
    .rf_addr0(rf_addr0), .rf_addr1(rf_addr1),
    .rf_data0(rf_data0), .rf_data1(rf_data1),
    .fwd_we(fwd_we), .fwd_load(fwd_load),
    .fwd_waddr(fwd_waddr), .fwd_wdata(fwd_wdata),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op(out_op), .out_phase(out_phase),
    .out_op0(out_op0), .out_op1(out_op1),
    .out_we(out_we), .out_waddr(out_waddr), .out_pc(out_pc),
    .br_valid(br_valid), .br_addr(br_addr),
    .stall_o(stall_o), .int_busy(int_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; in_pc = '0; in_imm = '0; in_re0 = 0; in_re1 = 0; in_use_imm = 0;
    in_addr0 = '0; in_addr1 = '0; in_waddr = '0; in_we = 0; in_int = 0;
    in_op = '0; in_int_no = '0; fwd_we = '0; fwd_load = '0; fwd_waddr = '0;
    fwd_wdata = '0; flush = 0;
  endtask

  task automatic set_alu(input logic [7:0] op, input logic [3:0] a0, input logic [3:0] a1,
                         input logic [3:0] wa, input logic [15:0] pc);
    in_valid = 1; in_int = 0; in_op = op; in_re0 = 1; in_re1 = 1; in_use_imm = 0;
    in_addr0 = a0; in_addr1 = a1; in_waddr = wa; in_we = 1; in_pc = pc;
  endtask

  task automatic set_int(input logic [3:0] no, input logic [15:0] pc);
    in_valid = 1; in_int = 1; in_int_no = no; in_pc = pc; in_op = 8'h80;
    in_re0 = 0; in_re1 = 0; in_use_imm = 0; in_we = 0;
  endtask

  task automatic test_reset();
    rst = 1; out_ready = 1; clear_inputs();
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    total++; if (br_valid !== 1'b0) begin bad++; $display("FAIL rst_br got=%b exp=0", br_valid); end
    total++; if ({out_op, out_phase, out_op0, out_op1, out_waddr, out_pc, br_addr} !== '0) begin
      bad++; $display("FAIL rst_data got op=%h op0=%h op1=%h pc=%h br=%h exp=0", out_op, out_op0, out_op1, out_pc, br_addr); end
    total++; if ({stall_o, int_busy} !== 2'b00) begin bad++; $display("FAIL rst_flags got=%b exp=00", {stall_o, int_busy}); end
    rst = 0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_forward();
    // Both sources write r1; youngest (0) wins.
    set_alu(8'h21, 4'd1, 4'd2, 4'd3, 16'h0010);
    fwd_we = 2'b11; fwd_waddr = {4'd1, 4'd1}; fwd_wdata = {16'h0009, 16'h0005};
    step();
    total++; if (out_valid !== 1'b1 || out_op0 !== 16'h0005) begin bad++; $display("FAIL fwd_young got v=%b op0=%h exp v=1 op0=0005", out_valid, out_op0); end
    total++; if (out_op1 !== 16'h1002 || out_phase !== 2'd0 || out_waddr !== 4'd3 || out_op !== 8'h21) begin
      bad++; $display("FAIL fwd_rest got op1=%h ph=%0d wa=%0d op=%h exp 1002/0/3/21", out_op1, out_phase, out_waddr, out_op); end
    // Only source 1 matches; operand 1 is immediate despite a re1 match.
    set_alu(8'h22, 4'd1, 4'd1, 4'd4, 16'h0012);
    in_use_imm = 1; in_imm = 16'h00AB;
    fwd_we = 2'b10; fwd_waddr = {4'd1, 4'd1}; fwd_wdata = {16'h0009, 16'h0005};
    step();
    total++; if (out_op0 !== 16'h0009 || out_op1 !== 16'h00AB) begin bad++; $display("FAIL fwd_old_imm got op0=%h op1=%h exp 0009/00AB", out_op0, out_op1); end
    // re0=0 forces zero; operand 1 misses forwarding and reads the RF.
    set_alu(8'h23, 4'd1, 4'd4, 4'd5, 16'h0014);
    in_re0 = 0; fwd_we = 2'b11; fwd_waddr = {4'd1, 4'd1};
    step();
    total++; if (out_op0 !== 16'h0000 || out_op1 !== 16'h1004 || out_pc !== 16'h0014) begin
      bad++; $display("FAIL fwd_re0 got op0=%h op1=%h pc=%h exp 0000/1004/0014", out_op0, out_op1, out_pc); end
    clear_inputs();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_hazard();
    set_alu(8'h31, 4'd2, 4'd5, 4'd6, 16'h0020);
    fwd_we = 2'b01; fwd_load = 2'b01; fwd_waddr = {4'd0, 4'd5}; fwd_wdata = {16'h0, 16'h7777};
    #1;
    total++; if (stall_o !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL haz_op1 got stall=%b rdy=%b exp 1/0", stall_o, in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL haz_bubble got=%b exp=0", out_valid); end
    fwd_load = 2'b00;
    #1;
    total++; if (stall_o !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL haz_clear got stall=%b rdy=%b exp 0/1", stall_o, in_ready); end
    step();
    total++; if (out_valid !== 1'b1 || out_op0 !== 16'h1002 || out_op1 !== 16'h7777) begin
      bad++; $display("FAIL haz_issue got v=%b op0=%h op1=%h exp 1/1002/7777", out_valid, out_op0, out_op1); end
    // Operand 0 hazard via older source while source 0 targets another reg.
    set_alu(8'h32, 4'd7, 4'd9, 4'd6, 16'h0022);
    fwd_we = 2'b11; fwd_load = 2'b10; fwd_waddr = {4'd7, 4'd3};
    #1;
    total++; if (stall_o !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL haz_op0 got stall=%b rdy=%b exp 1/0", stall_o, in_ready); end
    clear_inputs();
    step();
  endtask

  task automatic test_backpressure();
    set_alu(8'h33, 4'd1, 4'd2, 4'd3, 16'h0030);
    step();
    set_alu(8'h44, 4'd3, 4'd4, 4'd5, 16'h0032);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_op !== 8'h33 || out_op0 !== 16'h1001) begin
        bad++; $display("FAIL bp_hold%0d got rdy=%b v=%b op=%h op0=%h exp 0/1/33/1001", i, in_ready, out_valid, out_op, out_op0); end
      step();
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b exp=1", in_ready); end
    step();
    total++; if (out_op !== 8'h44 || out_op0 !== 16'h1003 || out_op1 !== 16'h1004) begin
      bad++; $display("FAIL bp_next got op=%h op0=%h op1=%h exp 44/1003/1004", out_op, out_op0, out_op1); end
    clear_inputs();
    step();
  endtask

  task automatic test_int();
    set_int(4'hA, 16'h0040);
    step();
    total++; if (out_valid !== 1'b1 || out_phase !== 2'd1 || out_op0 !== 16'h00F0 || out_op1 !== 16'h0040) begin
      bad++; $display("FAIL int_ph1 got v=%b ph=%0d op0=%h op1=%h exp 1/1/00F0/0040", out_valid, out_phase, out_op0, out_op1); end
    total++; if (out_we !== 1'b1 || out_waddr !== 4'd8 || int_busy !== 1'b1 || br_valid !== 1'b0) begin
      bad++; $display("FAIL int_ph1_ctl got we=%b wa=%0d busy=%b br=%b exp 1/8/1/0", out_we, out_waddr, int_busy, br_valid); end
    set_alu(8'h55, 4'd1, 4'd2, 4'd3, 16'h0042);
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL int_block got=%b exp=0", in_ready); end
    clear_inputs();
    step();
    total++; if (int_busy !== 1'b1 || out_valid !== 1'b0 || br_valid !== 1'b0) begin
      bad++; $display("FAIL int2_wait got busy=%b v=%b br=%b exp 1/0/0", int_busy, out_valid, br_valid); end
    // Phase-1 SP update is now in EX and must be forwarded.
    fwd_we = 2'b01; fwd_waddr = {4'd0, 4'd8}; fwd_wdata = {16'h0, 16'h00EE};
    step();
    total++; if (out_valid !== 1'b1 || out_phase !== 2'd2 || out_op0 !== 16'h00EE || out_op1 !== 16'h000A) begin
      bad++; $display("FAIL int_ph2 got v=%b ph=%0d op0=%h op1=%h exp 1/2/00EE/000A", out_valid, out_phase, out_op0, out_op1); end
    total++; if (br_valid !== 1'b1 || br_addr !== 16'h0008 || int_busy !== 1'b0 || out_waddr !== 4'd8) begin
      bad++; $display("FAIL int_br got br=%b addr=%h busy=%b wa=%0d exp 1/0008/0/8", br_valid, br_addr, int_busy, out_waddr); end
    clear_inputs();
    step();
    total++; if (br_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL int_pulse got br=%b v=%b exp 0/0", br_valid, out_valid); end
  endtask

  task automatic test_flush();
    set_int(4'h3, 16'h0050);
    step();
    clear_inputs();
    step();
    total++; if (int_busy !== 1'b1) begin bad++; $display("FAIL fl_in_int2 got=%b exp=1", int_busy); end
    flush = 1;
    step();
    flush = 0;
    total++; if (out_valid !== 1'b0 || br_valid !== 1'b0 || int_busy !== 1'b0) begin
      bad++; $display("FAIL fl_int2 got v=%b br=%b busy=%b exp 0/0/0", out_valid, br_valid, int_busy); end
    step();
    total++; if (br_valid !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL fl_after got br=%b v=%b exp 0/0", br_valid, out_valid); end
    // Flush beats a simultaneous capture.
    set_alu(8'h66, 4'd1, 4'd2, 4'd3, 16'h0060);
    flush = 1;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", in_ready); end
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_capture got=%b exp=0", out_valid); end
    clear_inputs();
    step();
  endtask

  task automatic test_rst_int1();
    set_int(4'h5, 16'h0070);
    step();
    clear_inputs();
    out_ready = 0;
    rst = 1;
    step();
    rst = 0; out_ready = 1;
    total++; if (out_valid !== 1'b0 || int_busy !== 1'b0 || br_valid !== 1'b0) begin
      bad++; $display("FAIL rst_int1 got v=%b busy=%b br=%b exp 0/0/0", out_valid, int_busy, br_valid); end
    total++; if ({out_op, out_phase, out_op0, out_op1, out_we, out_waddr, out_pc} !== '0) begin
      bad++; $display("FAIL rst_int1_data got op=%h ph=%0d op0=%h op1=%h exp 0", out_op, out_phase, out_op0, out_op1); end
    step(); step();
    total++; if (br_valid !== 1'b0 || out_valid !== 1'b0 || int_busy !== 1'b0) begin
      bad++; $display("FAIL rst_no_ph2 got br=%b v=%b busy=%b exp 0/0/0", br_valid, out_valid, int_busy); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 16'h1000 + 16'(i);
    rf[8] = 16'h00F0;
    test_reset();
    test_forward();
    test_hazard();
    test_backpressure();
    test_int();
    test_flush();
    test_rst_int1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/opnd_fetch.md
OPND_FETCH -- requirements
Module: opnd_fetch

Interface
REQ-001 Parameter DW, default 16, datapath width.
REQ-002 Parameter AW, default 4, register address width; covers GPRs plus SP/T/IH.
REQ-003 Parameter NFWD, default 2, forwarding source count; index 0 is youngest (EX).
REQ-004 Parameter SP_ADDR, default 4'd8, stack pointer address.
REQ-005 Parameter INT_VEC, default 16'h0008, interrupt handler address.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 in_valid/in_ready  in/out  1/1  decoded-instruction handshake.
REQ-009 in_pc, in_imm  in  DW each  instruction PC and extended immediate.
REQ-010 in_re0, in_re1, in_use_imm  in  1 each  operand read enables; in_use_imm selects in_imm for operand 1.
REQ-011 in_addr0, in_addr1, in_waddr  in  AW each  source and destination addresses.
REQ-012 in_we, in_int  in  1 each  write enable; instruction is INT.
REQ-013 in_op  in  8  opaque micro-op tag; in_int_no  in  4  interrupt number.
REQ-014 rf_addr0/rf_addr1  out  AW  register-file read addresses; rf_data0/rf_data1  in  DW  combinational read data.
REQ-015 fwd_we, fwd_load  in  NFWD  per-source write enable, and "data not yet available" (load in flight).
REQ-016 fwd_waddr  in  NFWD*AW; fwd_wdata  in  NFWD*DW  packed, source j at slice j.
REQ-017 flush  in  1  discard output register and any INT sequence.
REQ-018 out_valid/out_ready  out/in  1/1  ID/EX register handshake.
REQ-019 out_op 8, out_phase 2, out_op0 DW, out_op1 DW, out_we 1, out_waddr AW, out_pc DW  out  registered micro-op.
REQ-020 br_valid 1, br_addr DW  out  registered branch request; stall_o 1, int_busy 1  out.

Function
REQ-021 Operand k with re=0 SHALL be 0; otherwise first j (0..NFWD-1) with fwd_we[j] and fwd_waddr[j]==addr wins; no match SHALL use rf_data.
REQ-022 A winning source with fwd_load[j]=1 SHALL assert hazard; hazard on either operand SHALL raise stall_o (OR, not AND).
REQ-023 Operand 1 SHALL be in_imm when in_use_imm=1, regardless of in_re1.
REQ-024 in_ready = (!out_valid || out_ready) && !hazard && state==IDLE && !flush.
REQ-025 On in_valid&&in_ready, next edge SHALL load out_* from inputs, out_phase=0, out_valid=1.
REQ-026 If out_ready=1 and nothing is captured, out_valid SHALL clear next edge (bubble on hazard); if out_ready=0, out_* SHALL hold.
REQ-027 FSM states IDLE, INT1, INT2; accepting in_int=1 SHALL go IDLE->INT1.
REQ-028 INT accept SHALL emit phase 1: op0=SP operand (addr SP_ADDR, forwarded), op1=in_pc, we=1, waddr=SP_ADDR; int_no latched.
REQ-029 INT1->INT2 when phase-1 output is consumed; INT2 SHALL emit phase 2: op0=SP re-fetched via forwarding (hazard rules apply), op1=int_no zero-extended, we=1, waddr=SP_ADDR.
REQ-030 Phase-2 emission edge SHALL set br_valid=1 for one cycle with br_addr=INT_VEC; FSM returns to IDLE.
REQ-031 int_busy = (state!=IDLE); br_valid SHALL be 0 in all other cycles.
REQ-032 flush SHALL, next edge, clear out_valid and br_valid and set FSM IDLE; flush beats a simultaneous capture.

Reset
REQ-033 On rst: out_valid=0, br_valid=0, out_* data/addr/op/phase=0, br_addr=0, FSM IDLE; stall_o and int_busy then read 0.
REQ-034 rst mid-INT sequence SHALL abort it; no phase-2 or br_valid follows.

Verification
REQ-035 ADDU r1,r2 with fwd0 we r1=16'h0005, fwd1 we r1=16'h0009 -> out_op0=16'h0005 (youngest wins).
REQ-036 fwd_load[0]=1 targeting in_addr1 -> stall_o=1, in_ready=0, one bubble; fwd_load drops -> instruction issues with forwarded data.
REQ-037 INT no=4'hA at pc 16'h0040, SP=16'h00F0 -> phase1 op1=16'h0040, phase2 op1=16'h000A, br_valid pulse with br_addr=16'h0008.
REQ-038 out_ready=0 for 3 cycles with valid output -> out_* stable, in_ready=0; release -> next instruction captured.
REQ-039 flush during INT2 -> out_valid=0, no br_valid, int_busy=0 next cycle.
REQ-040 rst asserted in INT1 -> all outputs 0 next edge, FSM IDLE.
